// File: rtl/fir_pkg.sv
// Shared types, default parameters and the shift-and-saturate helper
// for the time-multiplexed FIR tap scheduler.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fir_sched_state_t;

    localparam int FIR_TAPS  = 4;
    localparam int FIR_DW    = 16;
    localparam int FIR_SHIFT = 15;

    // Arithmetic right shift followed by clamping to a signed dw-bit range.
    // Works on a 64-bit sign-extended accumulator so one function serves
    // every parameterisation; the caller narrows the result to dw bits.
    function automatic logic signed [63:0] fir_sat(
        input logic signed [63:0] acc,
        input int                 shift_amt,
        input int                 dw
    );
        logic signed [63:0] shifted;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        shifted = acc >>> shift_amt;
        hi      = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (dw - 1));
        if (shifted > hi) begin
            return hi;
        end else if (shifted < lo) begin
            return lo;
        end else begin
            return shifted;
        end
    endfunction

endpackage

// File: rtl/fir_tap_scheduler_if.sv
// Sample input, MAC control and filtered output signals of the scheduler.
// The master modport is the scheduler; the slave modport is its environment
// (sample source, shared MAC unit and downstream sink).
interface fir_tap_scheduler_if #(
    parameter int TAPS = 4,
    parameter int DW   = 16,
    parameter int ACCW = 2*DW + $clog2(TAPS)
);
    localparam int IW = $clog2(TAPS);

    logic                   in_valid;
    logic signed [DW-1:0]   in_data;
    logic                   in_ready;
    logic                   mac_en;
    logic                   mac_first;
    logic signed [DW-1:0]   mac_sample;
    logic        [IW-1:0]   mac_coef_idx;
    logic signed [ACCW-1:0] mac_acc;
    logic                   out_valid;
    logic signed [DW-1:0]   out_data;
    logic                   out_ready;

    modport master (
        input  in_valid, in_data, mac_acc, out_ready,
        output in_ready, mac_en, mac_first, mac_sample, mac_coef_idx,
               out_valid, out_data
    );

    modport slave (
        output in_valid, in_data, mac_acc, out_ready,
        input  in_ready, mac_en, mac_first, mac_sample, mac_coef_idx,
               out_valid, out_data
    );

endinterface

// File: rtl/fir_delay_line.sv
// Circular TAPS x DW sample store. One write port at an absolute address,
// one combinational read port addressed relative to the newest sample.
module fir_delay_line #(
    parameter int TAPS = 4,
    parameter int DW   = 16,
    parameter int AW   = $clog2(TAPS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wr_en,
    input  logic        [AW-1:0] i_wr_addr,
    input  logic signed [DW-1:0] i_wr_data,
    input  logic        [AW-1:0] i_newest,
    input  logic        [AW-1:0] i_tap,
    output logic signed [DW-1:0] o_rd_data
);

    logic signed [DW-1:0] r_mem [TAPS];
    logic        [AW:0]   w_wrap_sum;
    logic        [AW-1:0] w_rd_idx;

    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_entry
            // Each slot clears on reset and loads when addressed by the write port.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_mem[gi] <= '0;
                end else if (i_wr_en && (i_wr_addr == AW'(gi))) begin
                    r_mem[gi] <= i_wr_data;
                end
            end
        end
    endgenerate

    // (newest - tap) mod TAPS without relying on TAPS being a power of two.
    always_comb begin
        w_wrap_sum = {1'b0, i_newest} + (AW+1)'(TAPS) - {1'b0, i_tap};
        if (i_newest >= i_tap) begin
            w_rd_idx = i_newest - i_tap;
        end else begin
            w_rd_idx = w_wrap_sum[AW-1:0];
        end
    end

    assign o_rd_data = r_mem[w_rd_idx];

endmodule

// File: rtl/fir_tap_scheduler.sv
// Sequences one shared MAC over all taps of a FIR filter: accepts a sample,
// streams TAPS (sample, coefficient index) pairs to the MAC, then scales,
// saturates and holds the accumulator result on a valid/ready output.
module fir_tap_scheduler
    import fir_pkg::*;
#(
    parameter int TAPS  = FIR_TAPS,
    parameter int DW    = FIR_DW,
    parameter int ACCW  = 2*DW + $clog2(TAPS),
    parameter int SHIFT = FIR_SHIFT
) (
    input  logic                system1000,
    input  logic                system1000_rstn,
    fir_tap_scheduler_if.master bus
);

    localparam int TW = $clog2(TAPS);

    fir_sched_state_t     r_state;
    logic        [TW-1:0] r_wr_ptr;
    logic        [TW-1:0] r_newest;
    logic        [TW-1:0] r_tap;
    logic                 r_in_ready;
    logic                 r_mac_en;
    logic                 r_mac_first;
    logic signed [DW-1:0] r_mac_sample;
    logic        [TW-1:0] r_mac_coef_idx;
    logic                 r_out_valid;
    logic signed [DW-1:0] r_out_data;

    logic        [TW-1:0]   w_tap_next;
    logic        [TW-1:0]   w_wr_ptr_next;
    logic                   w_accept;
    logic signed [DW-1:0]   w_rd_data;
    logic signed [ACCW-1:0] w_acc;

    assign w_accept      = (r_state == ST_IDLE) && bus.in_valid;
    assign w_tap_next    = r_tap + TW'(1);
    assign w_wr_ptr_next = (r_wr_ptr == TW'(TAPS - 1)) ? '0 : r_wr_ptr + TW'(1);
    assign w_acc         = bus.mac_acc;

    // The read port looks one tap ahead so the registered MAC operand for
    // the next cycle is ready at the same edge the tap counter advances.
    fir_delay_line #(
        .TAPS (TAPS),
        .DW   (DW),
        .AW   (TW)
    ) u_delay_line (
        .i_clk     (system1000),
        .i_rst_n   (system1000_rstn),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.in_data),
        .i_newest  (r_newest),
        .i_tap     (w_tap_next),
        .o_rd_data (w_rd_data)
    );

    // Scheduler FSM; every output is registered as the value for the next state.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            r_state        <= ST_IDLE;
            r_wr_ptr       <= '0;
            r_newest       <= '0;
            r_tap          <= '0;
            r_in_ready     <= 1'b1;
            r_mac_en       <= 1'b0;
            r_mac_first    <= 1'b0;
            r_mac_sample   <= '0;
            r_mac_coef_idx <= '0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_newest       <= r_wr_ptr;
                        r_wr_ptr       <= w_wr_ptr_next;
                        r_tap          <= '0;
                        r_state        <= ST_RUN;
                        r_in_ready     <= 1'b0;
                        r_mac_en       <= 1'b1;
                        r_mac_first    <= 1'b1;
                        r_mac_coef_idx <= '0;
                        // Tap 0 is the sample being written right now, so
                        // bypass the delay line rather than wait for it.
                        r_mac_sample   <= bus.in_data;
                    end
                end
                ST_RUN: begin
                    if (r_tap == TW'(TAPS - 1)) begin
                        r_state        <= ST_WAIT;
                        r_mac_en       <= 1'b0;
                        r_mac_first    <= 1'b0;
                        r_mac_sample   <= '0;
                        r_mac_coef_idx <= '0;
                    end else begin
                        r_tap          <= w_tap_next;
                        r_mac_first    <= 1'b0;
                        r_mac_coef_idx <= w_tap_next;
                        r_mac_sample   <= w_rd_data;
                    end
                end
                ST_WAIT: begin
                    // The MAC registered its last product at the previous edge.
                    r_out_data  <= DW'(fir_sat(64'(w_acc), SHIFT, DW));
                    r_out_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.mac_en       = r_mac_en;
    assign bus.mac_first    = r_mac_first;
    assign bus.mac_sample   = r_mac_sample;
    assign bus.mac_coef_idx = r_mac_coef_idx;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_data     = r_out_data;

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Bench for fir_tap_scheduler with a behavioural MAC (all coefficients 0.5 in Q15).
module tb_fir_tap_scheduler;
    import fir_pkg::*;

    localparam int TAPS  = 4;
    localparam int DW    = 16;
    localparam int ACCW  = 2*DW + $clog2(TAPS);
    localparam int SHIFT = 15;
    localparam longint COEF = 16384;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    fir_tap_scheduler_if #(.TAPS(TAPS), .DW(DW), .ACCW(ACCW)) bus ();

    fir_tap_scheduler #(
        .TAPS  (TAPS),
        .DW    (DW),
        .ACCW  (ACCW),
        .SHIFT (SHIFT)
    ) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    // Behavioural MAC with an override path for the saturation cases.
    logic signed [ACCW-1:0] acc_reg;
    logic signed [ACCW-1:0] w_prod;
    logic signed [ACCW-1:0] ovr_val;
    logic                   ovr_en;

    assign w_prod      = ACCW'(bus.mac_sample) * ACCW'(COEF);
    assign bus.mac_acc = ovr_en ? ovr_val : acc_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_reg <= '0;
        end else if (bus.mac_en) begin
            acc_reg <= bus.mac_first ? w_prod : acc_reg + w_prod;
        end
    end

    int     checks   = 0;
    int     failures = 0;
    longint hist [TAPS];
    longint sb [$];

    typedef struct {
        longint din;
        longint exp_out;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint model_out();
        longint s;
        s = 0;
        for (int i = 0; i < TAPS; i++) s += hist[i] * COEF;
        s = s >>> SHIFT;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    function automatic void hist_clear();
        for (int i = 0; i < TAPS; i++) hist[i] = 0;
    endfunction

    // Called at a falling edge. Offers v, checks the TAPS-cycle MAC burst and
    // the WAIT bubble, and returns at the falling edge where out_valid rises.
    task automatic send_and_mac(input longint v, input longint exp, input bit use_exp);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(v);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready=%0d required 1", bus.in_ready);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = v;
        sb.push_back(use_exp ? exp : model_out());
        for (int k = 0; k < TAPS; k++) begin
            chk("mac_en", longint'(bus.mac_en), 1);
            chk("mac_first", longint'(bus.mac_first), longint'(k == 0));
            chk("mac_coef_idx", longint'(bus.mac_coef_idx), longint'(k));
            chk("mac_sample", longint'(bus.mac_sample), hist[k]);
            @(negedge clk);
        end
        chk("wait_mac_en", longint'(bus.mac_en), 0);
        chk("wait_out_valid", longint'(bus.out_valid), 0);
        @(negedge clk);
        chk("latency_out_valid", longint'(bus.out_valid), 1);
    endtask

    // Called at a falling edge with out_ready high; completes one output handshake.
    task automatic take_output();
        int n;
        longint exp;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid || sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out_timeout: out_valid=%0d pending=%0d", bus.out_valid, sb.size());
            return;
        end
        exp = sb.pop_front();
        $display("TXN out_data=%0d expected=%0d", bus.out_data, exp);
        chk("out_data", longint'(bus.out_data), exp);
        @(posedge clk);
        @(negedge clk);
        chk("post_hs_out_valid", longint'(bus.out_valid), 0);
        chk("post_hs_in_ready", longint'(bus.in_ready), 1);
    endtask

    initial begin
        longint held;
        tbl[0] = '{din: 1,     exp_out: 50};
        tbl[1] = '{din: 2,     exp_out: 51};
        tbl[2] = '{din: 3,     exp_out: 53};
        tbl[3] = '{din: 4,     exp_out: 5};
        tbl[4] = '{din: 5,     exp_out: 7};
        tbl[5] = '{din: -7,    exp_out: 2};
        tbl[6] = '{din: -100,  exp_out: -49};
        tbl[7] = '{din: -3,    exp_out: -53};
        tbl[8] = '{din: 32767, exp_out: 16328};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        ovr_en        = 1'b0;
        ovr_val       = '0;
        hist_clear();

        repeat (3) @(negedge clk);
        chk("rst_in_ready", longint'(bus.in_ready), 1);
        chk("rst_mac_en", longint'(bus.mac_en), 0);
        chk("rst_mac_first", longint'(bus.mac_first), 0);
        chk("rst_mac_sample", longint'(bus.mac_sample), 0);
        chk("rst_mac_coef_idx", longint'(bus.mac_coef_idx), 0);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_out_data", longint'(bus.out_data), 0);
        rstn = 1'b1;
        @(negedge clk);

        // Impulse: 100 * 0.5
        send_and_mac(100, 50, 1'b1);
        take_output();

        // Table: wrap-around and signed patterns
        for (int i = 0; i < 9; i++) begin
            send_and_mac(tbl[i].din, tbl[i].exp_out, 1'b1);
            take_output();
        end

        // Saturation via forced accumulator
        ovr_en  = 1'b1;
        ovr_val = ACCW'(64'sd2147483648);
        send_and_mac(1, 32767, 1'b1);
        take_output();
        ovr_val = ACCW'(-64'sd2147483648);
        send_and_mac(2, -32768, 1'b1);
        take_output();
        ovr_en = 1'b0;

        // Backpressure: output held, 999 offered but not taken
        bus.out_ready = 1'b0;
        send_and_mac(-5, 0, 1'b0);
        held = sb[0];
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(999);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_out_valid", longint'(bus.out_valid), 1);
            chk("bp_out_data", longint'(bus.out_data), held);
            chk("bp_in_ready", longint'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        take_output();
        send_and_mac(999, 0, 1'b0);
        take_output();

        // Reset during tap 2 of a run
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(77);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrun_tap", longint'(bus.mac_coef_idx), 2);
        rstn = 1'b0;
        #1;
        chk("midrun_rst_mac_en", longint'(bus.mac_en), 0);
        chk("midrun_rst_out_valid", longint'(bus.out_valid), 0);
        chk("midrun_rst_in_ready", longint'(bus.in_ready), 1);
        chk("midrun_rst_mac_sample", longint'(bus.mac_sample), 0);
        hist_clear();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        send_and_mac(300, 150, 1'b1);
        take_output();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fir_tap_scheduler.md
# fir_tap_scheduler

Time-multiplexing controller for the FIR filter. It accepts one signed 16-bit sample at a time from the stimulus path and keeps the last TAPS samples in a circular delay line. It then sequences a single shared multiply-accumulate unit over all taps. When the sum is ready, it scales and saturates the result and presents it on a valid/ready output port.

## Interface
- TAPS, 4, number of filter taps (≥2)
- DW, 16, sample/output width
- ACCW, 2*DW+$clog2(TAPS), MAC accumulator width
- SHIFT, 15, arithmetic right shift applied to accumulator (Q15 coefficients)

Ports:
- system1000  in  1  clock
- system1000_rstn  in  1  asynchronous reset, active low
- in_valid  in  1  input sample valid
- in_data  in  signed DW  input sample
- in_ready  out  1  scheduler can accept a sample
- mac_en  out  1  MAC accumulates this cycle
- mac_first  out  1  MAC loads product instead of adding (first tap)
- mac_sample  out  signed DW  delay-line operand for the MAC
- mac_coef_idx  out  $clog2(TAPS)  coefficient index for the MAC
- mac_acc  in  signed ACCW  registered MAC accumulator
- out_valid  out  1  filtered sample valid
- out_data  out  signed DW  filtered sample
- out_ready  in  1  downstream accepts out_data

## Operation
- States: IDLE, RUN, WAIT, HOLD.
- Reset values:
  - state = IDLE; delay line all zero; wr_ptr = 0; tap = 0.
  - in_ready = 1; mac_en = 0; mac_first = 0; mac_sample = 0; mac_coef_idx = 0.
  - out_valid = 0; out_data = 0.
- IDLE:
  - in_ready = 1.
  - When in_valid is high, write in_data at wr_ptr.
  - newest <= wr_ptr; wr_ptr <= (wr_ptr+1) mod TAPS; tap <= 0; go to RUN.
- RUN:
  - in_ready = 0 and mac_en = 1.
  - mac_first = (tap==0).
  - mac_coef_idx = tap.
  - mac_sample = delay[(newest − tap) mod TAPS].
  - tap increments each cycle; when tap==TAPS-1, go to WAIT.
- WAIT: one cycle for the MAC register to settle. At the end of the cycle, out_data <= sat(mac_acc >>> SHIFT) and out_valid <= 1; go to HOLD.
- HOLD:
  - out_valid = 1, and out_data stays stable.
  - When out_ready is high, clear out_valid and go to IDLE.
- Arithmetic:
  - The shift is an arithmetic (sign-preserving) shift.
  - Saturate to [−2^(DW−1), 2^(DW−1)−1], i.e. −32768..32767.
- Pointer wrap: wr_ptr and the read index wrap modulo TAPS, including when TAPS is not a power of two.
- in_valid outside IDLE is ignored, and the sample is not consumed.
- mac_sample, mac_coef_idx and mac_first are registered outputs. mac_en is registered from the state, so all MAC controls are glitch-free.
- Reset asserted in any state (including mid-RUN): all state returns to reset values immediately (asynchronously), and the delay line is zeroed.

## Timing
- Accept edge E0 (in_valid && in_ready).
- mac_en is high for exactly TAPS cycles, sampled by edges E1..E_TAPS.
- out_valid rises after edge E_(TAPS+1); latency is TAPS+1 cycles from acceptance to out_valid.
- Minimum sample period is TAPS+3 cycles, with out_ready held high.
- in_ready is high only in IDLE. Consequently, an output handshake and an input handshake never occur in the same cycle.

## Structure
- Package fir_pkg:
  - state enum fir_sched_state_t;
  - default TAPS/DW/SHIFT localparams;
  - function fir_sat(acc) for shift-and-saturate.
- Sub-module fir_delay_line:
  - TAPS×DW circular register file with async clear;
  - one write port and one read port addressed by the (newest − tap) offset.
- The scheduler FSM and tap counter live in fir_tap_scheduler.

## Test plan
- Bench setup: TAPS=4, with a behavioural MAC model (coef[k] = 16384, Q15 0.5) attached.
- Impulse: after reset, send 100.
  - MAC sees mac_sample 100,0,0,0 with mac_coef_idx 0,1,2,3, and mac_first only on the first cycle.
  - out_data = 50, with out_valid 5 cycles after acceptance.
- Wrap: send samples 1,2,3,4,5.
  - The fifth run sees mac_sample 5,4,3,2.
  - out_data = 7, since (14·16384)>>>15 = 7.
- Saturation: force mac_acc = +2^31 → out_data = 32767; force mac_acc = −2^31 → out_data = −32768.
- Backpressure: hold out_ready low for 10 cycles while in_valid is high with 999.
  - out_valid and out_data stay stable, in_ready stays 0, and 999 is not consumed.
  - 999 is accepted only after the output handshake.
- Reset mid-RUN: assert system1000_rstn low during tap 2.
  - mac_en and out_valid drop immediately.
  - After release, sending 300 gives mac_sample 300,0,0,0.
